// File: rtl/peak_window_meter.sv
// peak_window_meter
//   Per-channel windowed peak meter for time-multiplexed unsigned samples.
//   Samples are accepted in ACC. Once WIN_LEN samples have been accepted
//   across all channels, the block spends NCH cycles in DUMP. Each of those
//   cycles publishes one channel's peak and clip flag, in channel order.
//   Publishing a channel either clears its peak (MODE=0) or decays it by
//   acc >> DECAY_SH (MODE=1). The clip flag is always cleared on publish.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   valid      sample strobe
//   ch         channel index of the sample (CH_W bits)
//   data       unsigned sample (DATA_W bits)
//   clear      synchronous flush of all measurement state, same effect as rst
//   in_ready   high while the block accepts samples (ACC state)
//   peak_valid one-cycle strobe qualifying peak_ch / peak / clip
//   peak_ch    channel being published (0 when peak_valid=0)
//   peak       published window peak (0 when peak_valid=0)
//   clip       channel saw an all-ones sample in the window (0 when peak_valid=0)
module peak_window_meter #(
  parameter int DATA_W   = 12,
  parameter int NCH      = 2,
  parameter int WIN_LEN  = 1024,
  parameter int MODE     = 0,
  parameter int DECAY_SH = 3,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [CH_W-1:0]   ch,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              in_ready,
  output logic              peak_valid,
  output logic [CH_W-1:0]   peak_ch,
  output logic [DATA_W-1:0] peak,
  output logic              clip
);

  localparam int CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
  // One extra bit so NCH itself is representable for the range check.
  localparam logic [CH_W:0]    NCH_V    = (CH_W + 1)'(NCH);

  typedef enum logic {ACC = 1'b0, DUMP = 1'b1} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   didx;
  logic [DATA_W-1:0] acc      [NCH];
  logic              clip_acc [NCH];
  logic              accept;
  logic              flush;

  // Value left in a channel's accumulator after it has been published.
  function automatic logic [DATA_W-1:0] after_publish(input logic [DATA_W-1:0] a);
    if (MODE == 1) return a - (a >> DECAY_SH);
    else           return '0;
  endfunction

  assign flush    = rst || clear;
  assign in_ready = (state == ACC);
  assign accept   = valid && in_ready && ({1'b0, ch} < NCH_V) && !clear;

  always_comb begin
    state_n = state;
    case (state)
      ACC:     if (accept && cnt == CNT_LAST) state_n = DUMP;
      DUMP:    if (didx == CH_LAST)           state_n = ACC;
      default: state_n = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= ACC;
      cnt   <= '0;
      didx  <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc[i]      <= '0;
        clip_acc[i] <= 1'b0;
      end
    end else begin
      state <= state_n;
      if (accept) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (state == DUMP) didx <= (didx == CH_LAST) ? '0 : didx + 1'b1;
      // Accept and publish never coincide: accept requires ACC.
      for (int i = 0; i < NCH; i++) begin
        if (accept && ch == CH_W'(i)) begin
          if (data > acc[i]) acc[i] <= data;
          if (&data)         clip_acc[i] <= 1'b1;
        end else if (state == DUMP && didx == CH_W'(i)) begin
          acc[i]      <= after_publish(acc[i]);
          clip_acc[i] <= 1'b0;
        end
      end
    end
  end

  // Publish stage: outputs are a direct view of the channel selected by didx.
  always_comb begin
    peak_valid = 1'b0;
    peak_ch    = '0;
    peak       = '0;
    clip       = 1'b0;
    if (state == DUMP) begin
      peak_valid = 1'b1;
      peak_ch    = didx;
      for (int i = 0; i < NCH; i++) begin
        if (didx == CH_W'(i)) begin
          peak = acc[i];
          clip = clip_acc[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_peak_window_meter.sv
module tb_peak_window_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  ch = '0;
  logic [11:0] data = '0;
  logic        clear = 1'b0;

  logic        rdy0, pv0, pc0, cl0;
  logic [11:0] pk0;
  logic        rdy1, pv1, pc1, cl1;
  logic [11:0] pk1;
  logic        rdy2, pv2, cl2;
  logic [1:0]  pc2;
  logic [11:0] pk2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Hold/clear meter, 2 channels.
  peak_window_meter #(.DATA_W(12), .NCH(2), .WIN_LEN(4), .MODE(0), .DECAY_SH(3)) u0 (
    .clk(clk), .rst(rst), .valid(valid), .ch(ch[0:0]), .data(data), .clear(clear),
    .in_ready(rdy0), .peak_valid(pv0), .peak_ch(pc0), .peak(pk0), .clip(cl0));

  // Decay meter, 2 channels, shift 2.
  peak_window_meter #(.DATA_W(12), .NCH(2), .WIN_LEN(4), .MODE(1), .DECAY_SH(2)) u1 (
    .clk(clk), .rst(rst), .valid(valid), .ch(ch[0:0]), .data(data), .clear(clear),
    .in_ready(rdy1), .peak_valid(pv1), .peak_ch(pc1), .peak(pk1), .clip(cl1));

  // Hold/clear meter, 3 channels (ch=3 is out of range).
  peak_window_meter #(.DATA_W(12), .NCH(3), .WIN_LEN(4), .MODE(0), .DECAY_SH(3)) u2 (
    .clk(clk), .rst(rst), .valid(valid), .ch(ch), .data(data), .clear(clear),
    .in_ready(rdy2), .peak_valid(pv2), .peak_ch(pc2), .peak(pk2), .clip(cl2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int c, input int d);
    valid = 1'b1;
    ch    = 2'(c);
    data  = 12'(d);
    tick();
    valid = 1'b0;
    ch    = '0;
    data  = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pub0(input string tag, input int c, input int p, input int cl);
    chk({tag, "_pv0"}, int'(pv0), 1);
    chk({tag, "_ch0"}, int'(pc0), c);
    chk({tag, "_pk0"}, int'(pk0), p);
    chk({tag, "_cl0"}, int'(cl0), cl);
    chk({tag, "_rdy0"}, int'(rdy0), 0);
  endtask

  task automatic pub1(input string tag, input int c, input int p);
    chk({tag, "_pv1"}, int'(pv1), 1);
    chk({tag, "_ch1"}, int'(pc1), c);
    chk({tag, "_pk1"}, int'(pk1), p);
  endtask

  task automatic pub2(input string tag, input int c, input int p, input int cl);
    chk({tag, "_pv2"}, int'(pv2), 1);
    chk({tag, "_ch2"}, int'(pc2), c);
    chk({tag, "_pk2"}, int'(pk2), p);
    chk({tag, "_cl2"}, int'(cl2), cl);
  endtask

  task automatic idle0(input string tag);
    chk({tag, "_pv0"}, int'(pv0), 0);
    chk({tag, "_ch0"}, int'(pc0), 0);
    chk({tag, "_pk0"}, int'(pk0), 0);
    chk({tag, "_cl0"}, int'(cl0), 0);
    chk({tag, "_rdy0"}, int'(rdy0), 1);
  endtask

  initial begin
    // Reset: two cycles, then quiet outputs with in_ready high.
    do_reset();
    idle0("rst");
    chk("rst_pv1", int'(pv1), 0);
    chk("rst_rdy2", int'(rdy2), 1);
    chk("rst_pk2", int'(pk2), 0);

    // Basic window: ch0 100,300,200 then ch1 50.
    send(0, 100);
    send(0, 300);
    send(0, 200);
    chk("basic_pre_rdy0", int'(rdy0), 1);
    send(1, 50);
    pub0("basic_a", 0, 300, 0);
    pub1("basic_a", 0, 300);
    tick();
    pub0("basic_b", 1, 50, 0);
    pub1("basic_b", 1, 50);
    tick();
    idle0("basic_end");
    // Zero window: hold/clear gives 0,0; decay gives 300-75=225, 50-12=38.
    send(0, 0);
    send(1, 0);
    send(0, 0);
    send(1, 0);
    pub0("zero_a", 0, 0, 0);
    pub1("zero_a", 0, 225);
    tick();
    pub0("zero_b", 1, 0, 0);
    pub1("zero_b", 1, 38);
    tick();
    idle0("zero_end");

    // Decay: ch0 peak 400, next zero window publishes 400-100=300.
    do_reset();
    send(0, 400);
    send(0, 0);
    send(1, 0);
    send(0, 0);
    pub1("dec_a", 0, 400);
    tick();
    pub1("dec_b", 1, 0);
    tick();
    send(0, 0);
    send(1, 0);
    send(0, 0);
    send(1, 0);
    pub1("dec_c", 0, 300);
    pub0("dec_c", 0, 0, 0);
    tick();
    pub1("dec_d", 1, 0);

    // Clip and drop on the 3-channel meter.
    do_reset();
    send(0, 4095);
    send(3, 4000);            // out of range, dropped
    send(1, 10);
    send(2, 7);
    chk("drop_rng_rdy2", int'(rdy2), 1);
    chk("drop_rng_pv2", int'(pv2), 0);
    send(2, 3);
    // Beat presented during DUMP must be ignored.
    valid = 1'b1;
    ch    = 2'd0;
    data  = 12'd4000;
    pub2("clip_a", 0, 4095, 1);
    chk("clip_a_rdy2", int'(rdy2), 0);
    tick();
    valid = 1'b0;
    data  = '0;
    pub2("clip_b", 1, 10, 0);
    tick();
    pub2("clip_c", 2, 7, 0);
    tick();
    chk("clip_end_pv2", int'(pv2), 0);
    chk("clip_end_rdy2", int'(rdy2), 1);
    send(0, 0);
    send(0, 0);
    send(0, 0);
    chk("drop_dump_rdy2", int'(rdy2), 1);
    send(0, 0);
    pub2("clip_z_a", 0, 0, 0);
    tick();
    pub2("clip_z_b", 1, 0, 0);
    tick();
    pub2("clip_z_c", 2, 0, 0);

    // Abort during the first DUMP cycle: k=0 uses clear, k=1 uses rst.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      send(0, 9);
      send(1, 8);
      send(0, 7);
      send(1, 6);
      pub0($sformatf("abort%0d_a", k), 0, 9, 0);
      if (k == 0) clear = 1'b1;
      else        rst   = 1'b1;
      tick();
      clear = 1'b0;
      rst   = 1'b0;
      idle0($sformatf("abort%0d_b", k));
      send(1, 5);
      send(1, 5);
      send(1, 5);
      idle0($sformatf("abort%0d_c", k));
      send(1, 5);
      pub0($sformatf("abort%0d_d", k), 0, 0, 0);
      tick();
      pub0($sformatf("abort%0d_e", k), 1, 5, 0);
      tick();
      idle0($sformatf("abort%0d_f", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
